// File: rtl/clock_pattern_detector_if.sv
// Bundle between the LTSM/RX front end and clock_pattern_detector.
// Debug counter signals exist only when CLK_DET_DEBUG_EN is defined.
interface clock_pattern_detector_if;
  logic i_rx_ckp;
  logic i_rx_ckn;
  logic i_rx_track;
  logic i_start_detect;
  logic i_ltsm_in_reset;
  logic o_done;
  logic o_ckp_pass;
  logic o_ckn_pass;
  logic o_track_pass;
`ifdef CLK_DET_DEBUG_EN
  logic [7:0] o_ckp_good_cnt;
  logic [7:0] o_ckn_good_cnt;
  logic [7:0] o_track_good_cnt;
  logic [9:0] o_bad_cnt_sum;

  modport master (
    output i_rx_ckp, i_rx_ckn, i_rx_track, i_start_detect, i_ltsm_in_reset,
    input  o_done, o_ckp_pass, o_ckn_pass, o_track_pass,
    input  o_ckp_good_cnt, o_ckn_good_cnt, o_track_good_cnt, o_bad_cnt_sum
  );
  modport slave (
    input  i_rx_ckp, i_rx_ckn, i_rx_track, i_start_detect, i_ltsm_in_reset,
    output o_done, o_ckp_pass, o_ckn_pass, o_track_pass,
    output o_ckp_good_cnt, o_ckn_good_cnt, o_track_good_cnt, o_bad_cnt_sum
  );
`else
  modport master (
    output i_rx_ckp, i_rx_ckn, i_rx_track, i_start_detect, i_ltsm_in_reset,
    input  o_done, o_ckp_pass, o_ckn_pass, o_track_pass
  );
  modport slave (
    input  i_rx_ckp, i_rx_ckn, i_rx_track, i_start_detect, i_ltsm_in_reset,
    output o_done, o_ckp_pass, o_ckn_pass, o_track_pass
  );
`endif
endinterface

// File: rtl/clock_pattern_detector.sv
// Counts gated clock-pattern bursts on CKP/CKN/TRACK and grades each lane pass/fail.
// Define CLK_DET_DEBUG_EN to expose live good/bad burst counters.
module clock_pattern_detector #(
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned GAP_CYC    = 6,
  parameter int unsigned END_IDLE   = 64,
  parameter int unsigned WINDOW_CYC = 8192,
  parameter int unsigned PASS_MIN   = 120,
  parameter int unsigned MAX_BAD    = 2
) (
  input logic                     i_pll_clk,
  input logic                     i_rst,
  clock_pattern_detector_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StArmed, StCount, StDone} state_e;

  localparam logic [2:0] GapMax = 3'(GAP_CYC);

  state_e state_q, state_d;
  logic   start_q;
  logic   done_q, done_d;
  logic [2:0] samp, prev_q, edge_v, close;
  logic [2:0] pass_q, pass_d;
  logic [15:0] win_q, win_d;
  logic [6:0]  idle_q, idle_d;
  logic [2:0][4:0] ecnt_q, ecnt_d;
  logic [2:0][2:0] gap_q, gap_d;
  logic [2:0][7:0] good_q, good_d, bad_q, bad_d;
  logic start_rise, counting, win_exp, idle_end, to_done, arm, clear;

  assign samp       = {bus_io.i_rx_track, bus_io.i_rx_ckn, bus_io.i_rx_ckp};
  assign edge_v     = samp & ~prev_q;
  assign start_rise = bus_io.i_start_detect & ~start_q;
  assign counting   = (state_q == StArmed) || (state_q == StCount);
  assign win_exp    = counting && (win_q == 16'(WINDOW_CYC - 1));
  assign idle_end   = (state_q == StCount) && (edge_v == 3'b000) &&
                      (idle_q == 7'(END_IDLE - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_rise) state_d = StArmed;
      StArmed: begin
        if (win_exp)         state_d = StDone;
        else if (|edge_v)    state_d = StCount;
      end
      StCount: if (win_exp || idle_end) state_d = StDone;
      StDone:  if (!bus_io.i_start_detect) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus_io.i_ltsm_in_reset) state_d = StIdle;
  end

  assign to_done = counting && (state_d == StDone);
  assign arm     = (state_q == StIdle) && (state_d == StArmed);
  assign clear   = arm || bus_io.i_ltsm_in_reset;
  assign done_d  = (state_d == StDone);

  always_comb begin
    win_d  = win_q;
    idle_d = '0;
    if (clear) begin
      win_d = '0;
    end else if (counting) begin
      win_d = win_q + 16'd1;
      if (state_q == StCount && edge_v == 3'b000) idle_d = idle_q + 7'd1;
    end
  end

  // A burst closes either after GAP_CYC quiet cycles or when the run ends with it still open.
  always_comb begin
    ecnt_d = ecnt_q;
    gap_d  = gap_q;
    good_d = good_q;
    bad_d  = bad_q;
    pass_d = pass_q;
    close  = '0;
    for (int i = 0; i < 3; i++) begin
      if (clear) begin
        ecnt_d[i] = '0;
        gap_d[i]  = '0;
        good_d[i] = '0;
        bad_d[i]  = '0;
        pass_d[i] = 1'b0;
      end else if (counting) begin
        if (edge_v[i]) begin
          if (ecnt_q[i] != 5'd31) ecnt_d[i] = ecnt_q[i] + 5'd1;
          gap_d[i] = '0;
        end else if (gap_q[i] != GapMax) begin
          gap_d[i] = gap_q[i] + 3'd1;
        end
        close[i] = (ecnt_d[i] != 5'd0) &&
                   ((!edge_v[i] && (gap_q[i] == GapMax - 3'd1)) || to_done);
        if (close[i]) begin
          if (ecnt_d[i] == 5'(BURST_LEN)) begin
            if (good_q[i] != 8'hff) good_d[i] = good_q[i] + 8'd1;
          end else if (bad_q[i] != 8'hff) begin
            bad_d[i] = bad_q[i] + 8'd1;
          end
          ecnt_d[i] = '0;
        end
        if (to_done) begin
          pass_d[i] = (good_d[i] >= 8'(PASS_MIN)) && (bad_d[i] <= 8'(MAX_BAD));
        end
      end
    end
  end

  // start_q resets high so a start level held through reset release is not taken as a rise.
  always_ff @(posedge i_pll_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      start_q <= 1'b1;
      done_q  <= 1'b0;
      prev_q  <= '0;
      pass_q  <= '0;
      win_q   <= '0;
      idle_q  <= '0;
      ecnt_q  <= '0;
      gap_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= bus_io.i_start_detect;
      done_q  <= done_d;
      prev_q  <= samp;
      pass_q  <= pass_d;
      win_q   <= win_d;
      idle_q  <= idle_d;
      ecnt_q  <= ecnt_d;
      gap_q   <= gap_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end

  assign bus_io.o_done       = done_q;
  assign bus_io.o_ckp_pass   = pass_q[0];
  assign bus_io.o_ckn_pass   = pass_q[1];
  assign bus_io.o_track_pass = pass_q[2];

`ifdef CLK_DET_DEBUG_EN
  assign bus_io.o_ckp_good_cnt   = good_q[0];
  assign bus_io.o_ckn_good_cnt   = good_q[1];
  assign bus_io.o_track_good_cnt = good_q[2];
  assign bus_io.o_bad_cnt_sum    = 10'(bad_q[0]) + 10'(bad_q[1]) + 10'(bad_q[2]);
`else
  // Counters stay internal; only the pass results leave the block.
`endif

endmodule

// File: tb/tb_clock_pattern_detector.sv
// Directed bench for clock_pattern_detector: table of burst patterns plus
// hand-written window, LTSM-abort and async-reset sequences.
module tb_clock_pattern_detector;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  clock_pattern_detector_if bus ();

  clock_pattern_detector dut (
    .i_pll_clk (clk),
    .i_rst     (rst),
    .bus_io    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    int              n_special;
    logic [2:0][7:0] sp;
    logic [2:0][7:0] nm;
    int              total;
    logic [2:0]      exp_pass;
    logic [2:0][7:0] good;
    int              bad_sum;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input string name, input int ns,
                              input int s0, input int s1, input int s2,
                              input int n0, input int n1, input int n2,
                              input int total, input logic [2:0] pass,
                              input int g0, input int g1, input int g2, input int bsum);
    vec_t v;
    v.name = name; v.n_special = ns; v.total = total; v.exp_pass = pass; v.bad_sum = bsum;
    v.sp[0] = 8'(s0); v.sp[1] = 8'(s1); v.sp[2] = 8'(s2);
    v.nm[0] = 8'(n0); v.nm[1] = 8'(n1); v.nm[2] = 8'(n2);
    v.good[0] = 8'(g0); v.good[1] = 8'(g1); v.good[2] = 8'(g2);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic a, input logic b, input logic c);
    bus.i_rx_ckp   = a;
    bus.i_rx_ckn   = b;
    bus.i_rx_track = c;
    @(posedge clk);
    #1;
  endtask

  // n_x edges per lane as 1,0 pairs, then gap quiet cycles.
  task automatic burst(input int n0, input int n1, input int n2, input int gap);
    int m;
    m = (n0 > n1) ? n0 : n1;
    m = (n2 > m) ? n2 : m;
    for (int k = 0; k < m; k++) begin
      tick(k < n0, k < n1, k < n2);
      tick(1'b0, 1'b0, 1'b0);
    end
    repeat (gap) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic arm();
    bus.i_start_detect = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    bus.i_start_detect = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
  endtask

  function automatic int pass_vec();
    return {29'd0, bus.o_track_pass, bus.o_ckn_pass, bus.o_ckp_pass};
  endfunction

  task automatic run_pattern(input vec_t v, input bit drop);
    int w;
    arm();
    for (int b = 0; b < v.total; b++) begin
      if (b < v.n_special) burst(v.sp[0], v.sp[1], v.sp[2], 16);
      else                 burst(v.nm[0], v.nm[1], v.nm[2], 16);
    end
    check({v.name, "_done_early"}, bus.o_done, 0);
    w = 0;
    while (!bus.o_done && w < 200) begin
      tick(1'b0, 1'b0, 1'b0);
      w++;
    end
    check({v.name, "_done"}, bus.o_done, 1);
    check({v.name, "_done_latency"}, 1 + 16 + w, 64);
    check({v.name, "_pass"}, pass_vec(), int'(v.exp_pass));
`ifdef CLK_DET_DEBUG_EN
    check({v.name, "_good_ckp"}, bus.o_ckp_good_cnt, v.good[0]);
    check({v.name, "_good_ckn"}, bus.o_ckn_good_cnt, v.good[1]);
    check({v.name, "_good_trk"}, bus.o_track_good_cnt, v.good[2]);
    check({v.name, "_bad_sum"}, bus.o_bad_cnt_sum, v.bad_sum);
`endif
    if (drop) begin
      bus.i_start_detect = 1'b0;
      tick(1'b0, 1'b0, 1'b0);
      check({v.name, "_done_drop"}, bus.o_done, 0);
    end
  endtask

  initial begin
    int n;
    vecs[0] = mk("ideal",      0, 0, 0, 0,    16, 16, 16, 128, 3'b111, 128, 128, 128, 0);
    vecs[1] = mk("first15",    1, 15, 15, 15, 16, 16, 16, 128, 3'b111, 127, 127, 127, 3);
    vecs[2] = mk("ckn_stuck",  0, 0, 0, 0,    16, 0, 16,  128, 3'b101, 128, 0, 128, 0);
    vecs[3] = mk("trk_3x17",   3, 16, 16, 17, 16, 16, 16, 128, 3'b011, 128, 128, 125, 3);
    vecs[4] = mk("ckp_2x14",   2, 14, 16, 16, 16, 16, 16, 128, 3'b111, 126, 128, 128, 2);
    vecs[5] = mk("min_120",    0, 0, 0, 0,    16, 16, 16, 120, 3'b111, 120, 120, 120, 0);
    vecs[6] = mk("short_119",  0, 0, 0, 0,    16, 16, 16, 119, 3'b000, 119, 119, 119, 0);

    rst = 1'b1;
    bus.i_rx_ckp = 1'b0; bus.i_rx_ckn = 1'b0; bus.i_rx_track = 1'b0;
    bus.i_start_detect = 1'b0; bus.i_ltsm_in_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", bus.o_done, 0);
    check("rst_pass", pass_vec(), 0);
    #2 rst = 1'b0;
    tick(1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) run_pattern(vecs[i], 1'b1);

    // No edges after arm: window expiry forces DONE with all lanes failing.
    arm();
    n = 0;
    while (!bus.o_done && n < 9000) begin
      tick(1'b0, 1'b0, 1'b0);
      n++;
    end
    check("win_cycles", n, 8192);
    check("win_pass", pass_vec(), 0);
    bus.i_start_detect = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    check("win_done_drop", bus.o_done, 0);

    // LTSM abort mid-COUNT, then a clean re-arm.
    arm();
    repeat (3) burst(17, 17, 17, 16);
    repeat (5) burst(16, 16, 16, 16);
    bus.i_ltsm_in_reset = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    bus.i_ltsm_in_reset = 1'b0;
    check("ltsm_done", bus.o_done, 0);
    check("ltsm_pass", pass_vec(), 0);
    repeat (80) tick(1'b0, 1'b0, 1'b0);
    check("ltsm_no_rearm", bus.o_done, 0);
    run_pattern(vecs[0], 1'b1);

    // Async reset while DONE, with start held high through release.
    run_pattern(vecs[0], 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_done", bus.o_done, 0);
    check("arst_pass", pass_vec(), 0);
    #2 rst = 1'b0;
    repeat (3) burst(16, 16, 16, 16);
    repeat (100) tick(1'b0, 1'b0, 1'b0);
    check("arst_no_rearm", bus.o_done, 0);
    arm();
    repeat (2) burst(16, 16, 16, 16);
    n = 0;
    while (!bus.o_done && n < 200) begin
      tick(1'b0, 1'b0, 1'b0);
      n++;
    end
    check("rearm_done", bus.o_done, 1);
    check("rearm_latency", 1 + 16 + n, 64);
    check("rearm_pass", pass_vec(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
